fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 124 ++++++++++++
 tb/tb_fetch_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: single-outstanding instruction fetch stage.
// Fetches one word from instruction memory at the current PC, holds it for
// downstream decode until accepted, then redirects the PC (jump, branch or
// sequential) and fetches the next word.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req/imem_addr  read request and word-aligned address (= PC)
//   imem_ack/imem_rdata read response, sampled only in FETCH
//   instr_valid         instr/opcode/instr_pc4 hold a valid instruction
//   instr_ready         downstream accepts the held instruction
//   instr, opcode       held instruction word and its [31:26] field
//   instr_pc4           PC of the held instruction plus 4
//   jump, branch_taken  redirect controls, sampled only on accept
//   instr_count         number of accepted instructions (wraps)
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [31:0] instr_pc4,
    input  logic        jump,
    input  logic        branch_taken,
    output logic [31:0] instr_count
);

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] PC_INIT = RESET_PC & 32'hFFFF_FFFC;

    typedef enum logic {
        S_FETCH = 1'b0,
        S_VALID = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic              req_d;
    logic              valid_d;
    logic              fetch_ack;
    logic              accept;
    logic [XLEN-1:0]   pc_q;
    logic [XLEN-1:0]   next_pc;
    logic [XLEN-1:0]   branch_off;

    // Capture only while a request is actually outstanding.
    assign fetch_ack = (state_q == S_FETCH) && imem_req && imem_ack;
    assign accept    = (state_q == S_VALID) && instr_ready;

    assign imem_addr = pc_q;
    assign opcode    = instr[31:26];

    // State register with registered handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_FETCH;
            imem_req    <= 1'b0;
            instr_valid <= 1'b0;
        end else begin
            state_q     <= state_d;
            imem_req    <= req_d;
            instr_valid <= valid_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: if (fetch_ack) state_d = S_VALID;
            S_VALID: if (accept)    state_d = S_FETCH;
            default: state_d = S_FETCH;
        endcase
    end

    // Output decode of the upcoming state, registered above.
    always_comb begin
        req_d   = 1'b0;
        valid_d = 1'b0;
        case (state_d)
            S_FETCH: req_d   = 1'b1;
            S_VALID: valid_d = 1'b1;
            default: req_d   = 1'b0;
        endcase
    end

    // Redirect selection; jump has priority over a taken branch.
    always_comb begin
        branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};
        next_pc    = instr_pc4;
        if (jump) begin
            next_pc = {instr_pc4[31:28], instr[25:0], 2'b00};
        end else if (branch_taken) begin
            next_pc = instr_pc4 + branch_off;
        end
    end

    // PC, held instruction and accept counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= PC_INIT;
            instr       <= '0;
            instr_pc4   <= '0;
            instr_count <= '0;
        end else begin
            if (fetch_ack) begin
                instr     <= imem_rdata;
                instr_pc4 <= pc_q + XLEN'(4);
            end
            if (accept) begin
                pc_q        <= next_pc;
                instr_count <= instr_count + XLEN'(1);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed self-checking bench for fetch_unit.
module tb_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc4;
    logic        jump;
    logic        branch_taken;
    logic [31:0] instr_count;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_count = 32'd0;

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc4   (instr_pc4),
        .jump        (jump),
        .branch_taken(branch_taken),
        .instr_count (instr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Expect FETCH at addr, return data with a zero-wait ack.
    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data);
        chk({tag, "_addr"}, imem_addr, addr);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        imem_ack   = 1'b1;
        imem_rdata = data;
        tick();
        imem_ack   = 1'b0;
        chk({tag, "_valid"}, {31'd0, instr_valid}, 32'd1);
        chk({tag, "_req0"}, {31'd0, imem_req}, 32'd0);
        chk({tag, "_instr"}, instr, data);
        chk({tag, "_pc4"}, instr_pc4, addr + 32'd4);
    endtask

    // Accept the held instruction and expect the next fetch address.
    task automatic accept(input string tag, input logic j, input logic b, input logic [31:0] nxt);
        instr_ready  = 1'b1;
        jump         = j;
        branch_taken = b;
        tick();
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        exp_count    = exp_count + 32'd1;
        chk({tag, "_cnt"}, instr_count, exp_count);
        chk({tag, "_req"}, {31'd0, imem_req}, 32'd1);
        chk({tag, "_valid0"}, {31'd0, instr_valid}, 32'd0);
        chk({tag, "_next"}, imem_addr, nxt);
    endtask

    initial begin
        rst_n        = 1'b1;
        imem_ack     = 1'b0;
        imem_rdata   = 32'd0;
        instr_ready  = 1'b0;
        jump         = 1'b0;
        branch_taken = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        // Reset state
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_addr", imem_addr, 32'd0);
        chk("rst_instr", instr, 32'd0);
        chk("rst_pc4", instr_pc4, 32'd0);
        chk("rst_cnt", instr_count, 32'd0);
        tick();
        tick();
        chk("rst_hold_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b1;
        chk("rel_req_before_edge", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rel_req_first_edge", {31'd0, imem_req}, 32'd1);

        // Sequential stream with zero-wait memory
        fetch("seq0", 32'd0, 32'h2008_0005);
        chk("seq0_opcode", {26'd0, opcode}, 32'h0000_0008);
        accept("seq0", 1'b0, 1'b0, 32'd4);
        fetch("seq1", 32'd4, 32'h2008_0005);
        accept("seq1", 1'b0, 1'b0, 32'd8);
        fetch("seq2", 32'd8, 32'h2008_0005);
        accept("seq2", 1'b0, 1'b0, 32'd12);
        chk("seq_cnt3", instr_count, 32'd3);

        // instr_ready ignored in FETCH
        instr_ready = 1'b1;
        tick();
        instr_ready = 1'b0;
        chk("rdy_in_fetch_req", {31'd0, imem_req}, 32'd1);
        chk("rdy_in_fetch_cnt", instr_count, 32'd3);
        chk("rdy_in_fetch_addr", imem_addr, 32'd12);

        // Jump to 0x100, then jump to self at 0x100
        fetch("j0", 32'd12, 32'h0800_0040);
        accept("j0", 1'b1, 1'b0, 32'h0000_0100);
        fetch("j1", 32'h100, 32'h0800_0040);
        accept("j1", 1'b1, 1'b0, 32'h0000_0100);
        fetch("j2", 32'h100, 32'h0800_0080);
        accept("j2", 1'b1, 1'b0, 32'h0000_0200);

        // Backward branch: 0x204 - 8
        fetch("beq", 32'h200, 32'h1000_FFFE);
        chk("beq_opcode", {26'd0, opcode}, 32'h0000_0004);
        accept("beq", 1'b0, 1'b1, 32'h0000_01FC);
        fetch("j3", 32'h1FC, 32'h0800_0080);
        accept("j3", 1'b1, 1'b0, 32'h0000_0200);

        // Jump and branch together: jump wins
        fetch("jb", 32'h200, 32'h1000_FFFE);
        accept("jb", 1'b1, 1'b1, 32'h0003_FFF8);

        // Backpressure: 5 cycles not ready, with noise on jump and imem_ack
        fetch("bp", 32'h0003_FFF8, 32'h0800_0040);
        for (int i = 0; i < 5; i++) begin
            jump         = 1'b1;
            branch_taken = 1'b1;
            imem_ack     = 1'b1;
            imem_rdata   = 32'hDEAD_BEEF;
            tick();
            chk("bp_instr", instr, 32'h0800_0040);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
            chk("bp_valid", {31'd0, instr_valid}, 32'd1);
            chk("bp_cnt", instr_count, exp_count);
        end
        imem_ack = 1'b0;
        accept("bp", 1'b0, 1'b0, 32'h0003_FFFC);

        // Memory stall: 3 cycles without ack
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_addr", imem_addr, 32'h0003_FFFC);
            chk("stall_valid", {31'd0, instr_valid}, 32'd0);
            chk("stall_req", {31'd0, imem_req}, 32'd1);
        end

        // Wraparound: jump to 0, branch back to 0xFFFF_FFFC, fall through to 0
        fetch("jz", 32'h0003_FFFC, 32'h0800_0000);
        accept("jz", 1'b1, 1'b0, 32'h0000_0000);
        fetch("bw", 32'h0, 32'h1000_FFFE);
        accept("bw", 1'b0, 1'b1, 32'hFFFF_FFFC);
        fetch("wrap", 32'hFFFF_FFFC, 32'h0000_0000);
        accept("wrap", 1'b0, 1'b0, 32'h0000_0000);
        fetch("n0", 32'h0, 32'h0000_0000);
        accept("n0", 1'b0, 1'b0, 32'h0000_0004);
        fetch("n1", 32'h4, 32'h2008_0005);

        // Async reset in VALID
        rst_n = 1'b0;
        #1;
        chk("arst_valid", {31'd0, instr_valid}, 32'd0);
        chk("arst_req", {31'd0, imem_req}, 32'd0);
        chk("arst_addr", imem_addr, 32'd0);
        chk("arst_instr", instr, 32'd0);
        chk("arst_cnt", instr_count, 32'd0);
        #2 rst_n = 1'b1;
        exp_count = 32'd0;
        tick();
        chk("arst_rel_req", {31'd0, imem_req}, 32'd1);
        fetch("post", 32'h0, 32'h2008_0005);
        accept("post", 1'b0, 1'b0, 32'h0000_0004);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
